// File: rtl/cache_direct_mapped_if.sv
// Requester and burst-RAM signal bundle for cache_direct_mapped.
// slave is the cache side; master is the requester plus RAM side.
interface cache_direct_mapped_if #(
   parameter int BURST_RAM_DEPTH_BITWIDTH = 4
);
   logic [31:0] address;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic [31:0] data_in;
   logic [3:0]  write_enable;
   logic        busy;
   logic        br_cmd;
   logic        br_cmd_en;
   logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data;
   logic        br_rd_data_valid;

   modport slave (
      input  address, data_in, write_enable,
      input  br_rd_data, br_rd_data_valid,
      output data_out, data_out_ready, busy,
      output br_cmd, br_cmd_en, br_addr,
      output br_wr_data, br_data_mask
   );

   modport master (
      output address, data_in, write_enable,
      output br_rd_data, br_rd_data_valid,
      input  data_out, data_out_ready, busy,
      input  br_cmd, br_cmd_en, br_addr,
      input  br_wr_data, br_data_mask
   );
endinterface

// File: rtl/cache_direct_mapped.sv
// Direct-mapped write-back write-allocate cache, 32 B lines,
// 32-bit requester side, 4 x 64-bit burst RAM side.
module cache_direct_mapped #(
   parameter int LINE_IX_BITWIDTH         = 10,
   parameter int BURST_RAM_DEPTH_BITWIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   cache_direct_mapped_if.slave bus
);
   localparam int LW    = LINE_IX_BITWIDTH;
   localparam int TW    = 32 - 5 - LW;
   localparam int LINES = 2 ** LW;
   localparam int BW    = BURST_RAM_DEPTH_BITWIDTH;

   typedef enum logic [2:0] {
      IDLE, WB_CMD, WB_DATA, RD_CMD, RD_WAIT
   } state_t;

   state_t state, state_nx;
   logic [1:0] beat, beat_nx;

   // entry = {valid, dirty, tag}; zero-filled at configuration time
   logic [TW+1:0] tag_mem  [LINES]   = '{default: '0};
   // one 64-bit row per burst beat, i.e. two words
   logic [63:0]   data_mem [LINES*4] = '{default: '0};

   logic [TW+1:0] tag_q;
   logic [63:0]   data_q;

   logic          req_v;
   logic [31:2]   req_addr;
   logic [31:0]   req_data;
   logic [3:0]    req_we;

   logic [LW-1:0] line;
   logic [TW-1:0] tag;
   logic          hit, miss, take, wb_rd;
   logic [31:2]   la;
   logic [LW+1:0] draddr, dwaddr;
   logic [7:0]    dwe;
   logic [63:0]   dwdata;
   logic          twe;
   logic [TW+1:0] twdata;
   logic          br_cmd, br_cmd_en;
   logic [BW-1:0] br_addr;
   logic          unused_addr;

   assign line = req_addr[5 +: LW];
   assign tag  = req_addr[31 -: TW];
   assign hit  = req_v && tag_q[TW+1] && (tag_q[TW-1:0] == tag);
   assign miss = req_v && !hit && (state == IDLE);
   // a new request is accepted only when the current one is done
   assign take = (state == IDLE) && !miss;
   assign la   = take ? bus.address[31:2] : req_addr;
   assign wb_rd = (state == WB_CMD) || (state == WB_DATA) ||
                  (miss && tag_q[TW]);
   assign draddr = wb_rd ? {line, beat_nx} : {la[5 +: LW], la[4:3]};
   assign unused_addr = ^bus.address[1:0];

   assign bus.data_out       = req_addr[2] ? data_q[63:32] : data_q[31:0];
   assign bus.data_out_ready = (state == IDLE) && hit;
   assign bus.busy           = (state != IDLE) || miss;
   assign bus.br_cmd         = br_cmd;
   assign bus.br_cmd_en      = br_cmd_en;
   assign bus.br_addr        = br_addr;
   assign bus.br_wr_data     = data_q;
   assign bus.br_data_mask   = 8'h00;

   // hold the request being looked up; frozen while a miss is serviced
   always_ff @(posedge clk) begin
      if (rst) begin
         req_v <= 1'b0;
      end else if (take) begin
         req_v    <= 1'b1;
         req_addr <= bus.address[31:2];
         req_data <= bus.data_in;
         req_we   <= bus.write_enable;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         beat  <= 2'd0;
      end else begin
         state <= state_nx;
         beat  <= beat_nx;
      end
   end

   // FSM next state and burst command outputs
   always_comb begin
      state_nx  = state;
      beat_nx   = beat;
      br_cmd    = 1'b0;
      br_cmd_en = 1'b0;
      br_addr   = BW'({tag, line, 2'b00});
      unique case (state)
         IDLE: begin
            beat_nx = 2'd0;
            if (miss)
               state_nx = tag_q[TW] ? WB_CMD : RD_CMD;
         end
         WB_CMD: begin
            br_cmd    = 1'b1;
            br_cmd_en = 1'b1;
            br_addr   = BW'({tag_q[TW-1:0], line, 2'b00});
            beat_nx   = 2'd1;
            state_nx  = WB_DATA;
         end
         WB_DATA: begin
            br_cmd  = 1'b1;
            beat_nx = beat + 2'd1;
            if (beat == 2'd3)
               state_nx = RD_CMD;
         end
         RD_CMD: begin
            br_cmd_en = 1'b1;
            beat_nx   = 2'd0;
            state_nx  = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.br_rd_data_valid) begin
               beat_nx = beat + 2'd1;
               if (beat == 2'd3)
                  state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // memory write port: burst fill or byte-masked hit write
   always_comb begin
      dwe    = 8'h00;
      dwaddr = {line, beat};
      dwdata = bus.br_rd_data;
      twe    = 1'b0;
      twdata = {2'b10, tag};
      if (state == RD_WAIT && bus.br_rd_data_valid) begin
         dwe = 8'hFF;
         twe = (beat == 2'd3);
      end else if (state == IDLE && hit && req_we != 4'd0) begin
         dwaddr = {line, req_addr[4:3]};
         dwdata = {req_data, req_data};
         dwe    = req_addr[2] ? {req_we, 4'h0} : {4'h0, req_we};
         twe    = 1'b1;
         twdata = {2'b11, tag};
      end
   end

   // tag memory, registered write-first read
   always_ff @(posedge clk) begin
      if (twe)
         tag_mem[line] <= twdata;
      if (twe && line == la[5 +: LW])
         tag_q <= twdata;
      else
         tag_q <= tag_mem[la[5 +: LW]];
   end

   // data memory, registered write-first read with byte enables
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (dwe[b])
            data_mem[dwaddr][8*b +: 8] <= dwdata[8*b +: 8];
         if (dwe[b] && dwaddr == draddr)
            data_q[8*b +: 8] <= dwdata[8*b +: 8];
         else
            data_q[8*b +: 8] <= data_mem[draddr][8*b +: 8];
      end
   end
endmodule

// File: tb/tb_cache_direct_mapped.sv
// Directed bench for cache_direct_mapped with a small burst RAM model.
// Two lines of cache, sixteen 64-bit RAM rows.
module tb_cache_direct_mapped;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   wb_cnt = 0, rd_cnt = 0;
   int   wb_addr_last = -1, rd_addr_last = -1;
   logic [63:0] ram [16];

   cache_direct_mapped_if #(.BURST_RAM_DEPTH_BITWIDTH(4)) bus ();

   cache_direct_mapped #(
      .LINE_IX_BITWIDTH(1),
      .BURST_RAM_DEPTH_BITWIDTH(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] we, output logic fb,
                         output logic fr, output logic [31:0] dout,
                         output logic rdy);
      int n;
      bus.address      = a;
      bus.data_in      = d;
      bus.write_enable = we;
      @(posedge clk); #1;
      fb = bus.busy;
      fr = bus.data_out_ready;
      n = 0;
      while (bus.busy === 1'b1 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("busy_timeout", {63'd0, n >= 60}, 64'd0);
      dout = bus.data_out;
      rdy  = bus.data_out_ready;
   endtask

   // burst RAM responder: write bursts are stored, read bursts
   // come back after one idle cycle with a gap after beat 1
   initial begin
      int a;
      bus.br_rd_data       = '0;
      bus.br_rd_data_valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.br_cmd_en === 1'b1) begin
            a = int'(bus.br_addr);
            if (bus.br_cmd === 1'b1) begin
               wb_cnt++;
               wb_addr_last = a;
               ram[a] = bus.br_wr_data;
               for (int k = 1; k < 4; k++) begin
                  @(posedge clk); #1;
                  ram[a+k] = bus.br_wr_data;
               end
            end else begin
               rd_cnt++;
               rd_addr_last = a;
               @(posedge clk); #1;
               for (int k = 0; k < 4; k++) begin
                  bus.br_rd_data       = ram[a+k];
                  bus.br_rd_data_valid = 1'b1;
                  @(posedge clk); #1;
                  bus.br_rd_data_valid = 1'b0;
                  if (k == 1) begin
                     @(posedge clk); #1;
                  end
               end
            end
         end
      end
   end

   initial begin
      logic        fb, fr, rdy;
      logic [31:0] dout;
      int          n, rc, wc;
      for (int i = 0; i < 16; i++) ram[i] = '0;
      ram[1] = {32'h9D8E2F17, 32'hAB4C3E6F};
      ram[2] = {32'h00000000, 32'hD5B8A9C4};
      ram[4] = {32'h00000000, 32'h2F5E3C7A};
      bus.address      = 32'h10;
      bus.data_in      = '0;
      bus.write_enable = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_ready", {63'd0, bus.data_out_ready}, 64'd0);
      chk("rst_cmd_en", {63'd0, bus.br_cmd_en}, 64'd0);
      chk("rst_cmd", {63'd0, bus.br_cmd}, 64'd0);
      chk("mask", {56'd0, bus.br_data_mask}, 64'd0);
      rst = 1'b0;

      access(32'h10, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r10_first_busy", {63'd0, fb}, 64'd1);
      chk("r10_first_ready", {63'd0, fr}, 64'd0);
      chk("r10_data", {32'd0, dout}, {32'd0, 32'hD5B8A9C4});
      chk("r10_ready", {63'd0, rdy}, 64'd1);
      chk("r10_rd_addr", rd_addr_last, 64'd0);
      chk("r10_no_wb", wb_cnt, 64'd0);

      access(32'h08, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r08_first_busy", {63'd0, fb}, 64'd0);
      chk("r08_data", {32'd0, dout}, {32'd0, 32'hAB4C3E6F});
      chk("r08_ready", {63'd0, rdy}, 64'd1);

      access(32'h20, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r20_first_ready", {63'd0, fr}, 64'd0);
      chk("r20_data", {32'd0, dout}, {32'd0, 32'h2F5E3C7A});
      chk("r20_rd_addr", rd_addr_last, 64'd4);

      access(32'h0C, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r0c_first_busy", {63'd0, fb}, 64'd0);
      chk("r0c_data", {32'd0, dout}, {32'd0, 32'h9D8E2F17});

      access(32'h08, 32'h000000AD, 4'b0001, fb, fr, dout, rdy);
      chk("w08a_busy", {63'd0, fb}, 64'd0);
      access(32'h08, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("w08a_read", {32'd0, dout}, {32'd0, 32'hAB4C3EAD});
      access(32'h08, 32'h00008765, 4'b0011, fb, fr, dout, rdy);
      access(32'h08, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("w08b_read", {32'd0, dout}, {32'd0, 32'hAB4C8765});
      access(32'h08, 32'hFEEF0000, 4'b1100, fb, fr, dout, rdy);
      access(32'h08, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("w08c_read", {32'd0, dout}, {32'd0, 32'hFEEF8765});
      chk("w08c_first_busy", {63'd0, fb}, 64'd0);

      rc = rd_cnt;
      access(32'h40, 32'hABCDEF12, 4'b1111, fb, fr, dout, rdy);
      chk("w40_first_busy", {63'd0, fb}, 64'd1);
      chk("w40_ready", {63'd0, rdy}, 64'd1);
      chk("w40_wb_cnt", wb_cnt, 64'd1);
      chk("w40_wb_addr", wb_addr_last, 64'd0);
      chk("w40_wb_word2", ram[1], {32'h9D8E2F17, 32'hFEEF8765});
      chk("w40_rd_addr", rd_addr_last, 64'd8);
      chk("w40_rd_cnt", rd_cnt, rc + 1);
      access(32'h40, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r40_first_busy", {63'd0, fb}, 64'd0);
      chk("r40_data", {32'd0, dout}, {32'd0, 32'hABCDEF12});

      access(32'h40, 32'h1B2D3F42, 4'b1111, fb, fr, dout, rdy);
      chk("w40h_busy", {63'd0, fb}, 64'd0);
      access(32'h40, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("w40h_first_busy", {63'd0, fb}, 64'd0);
      chk("w40h_data", {32'd0, dout}, {32'd0, 32'h1B2D3F42});

      access(32'h08, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("rr08_first_busy", {63'd0, fb}, 64'd1);
      chk("rr08_data", {32'd0, dout}, {32'd0, 32'hFEEF8765});
      chk("rr08_wb_addr", wb_addr_last, 64'd8);
      chk("rr08_wb_data", ram[8], {32'h0, 32'h1B2D3F42});

      wc = wb_cnt;
      bus.address      = 32'h60;
      bus.write_enable = 4'h0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.br_cmd_en !== 1'b1 && n < 40);
      chk("r60_cmd_seen", {63'd0, bus.br_cmd_en}, 64'd1);
      chk("r60_rd_addr", {60'd0, bus.br_addr}, 64'd12);
      chk("r60_no_wb", wb_cnt, wc);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      bus.address = 32'h08;
      @(posedge clk); #1;
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_cmd_en", {63'd0, bus.br_cmd_en}, 64'd0);
      chk("abort_ready", {63'd0, bus.data_out_ready}, 64'd0);
      rst = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
      end
      chk("idle_cmd_en", {63'd0, bus.br_cmd_en}, 64'd0);
      rc = rd_cnt;
      access(32'h60, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r60_refill_busy", {63'd0, fb}, 64'd1);
      chk("r60_refill_cnt", rd_cnt, rc + 1);
      chk("r60_data", {32'd0, dout}, 64'd0);
      chk("r60_ready", {63'd0, rdy}, 64'd1);
      access(32'h20, 32'h0, 4'h0, fb, fr, dout, rdy);
      chk("r20_again_busy", {63'd0, fb}, 64'd1);
      chk("r20_again_data", {32'd0, dout}, {32'd0, 32'h2F5E3C7A});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
